// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-SRAM arbiter: requester IDs and the default
// debug starvation bound.
package dmem_arbiter_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_id_t;

    localparam int DEFAULT_MAX_WAIT = 4;

endpackage

// File: rtl/dmem_rd_return.sv
// Read-return pipeline: remembers who issued last cycle's SRAM read and steers
// the one-cycle-late read data back to that requester only.
module dmem_rd_return
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_rd,
    input  port_id_t              issue_port,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    logic     rd_pend;
    port_id_t rd_owner;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_CPU;
        end else begin
            rd_pend <= issue_rd;
            if (issue_rd) begin
                rd_owner <= issue_port;
            end
        end
    end

    // NOTE: every output gets a default before the branches; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        if (rd_pend) begin
            if (rd_owner == PORT_DBG) begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = mem_rdata;
            end else begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = mem_rdata;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority CPU/debug arbiter for the single-port data SRAM, with a
// starvation counter that forces a debug slot after MAX_WAIT lost cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int D_ADDR_WIDTH = 7,
    parameter int MAX_WAIT     = DEFAULT_MAX_WAIT
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [D_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_stall,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,

    input  logic                    dbg_req,
    input  logic                    dbg_we,
    input  logic [D_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    output logic                    dbg_gnt,
    output logic                    dbg_stall,
    output logic                    dbg_rvalid,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,

    output logic                    mem_cs,
    output logic                    mem_we,
    output logic [D_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              dbg_prio;

    assign dbg_prio = (wait_cnt == WAIT_W'(MAX_WAIT));

    // Requests are ignored entirely while reset is held low.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (reset) begin
            if (dbg_prio && dbg_req) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign dbg_stall = dbg_req & ~dbg_gnt;

    always_comb begin
        mem_cs    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Counts consecutive cycles a live debug request has lost; holds at the bound.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            wait_cnt <= '0;
        end else if (!dbg_prio) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    dmem_rd_return #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_return (
        .clk        (clk),
        .reset      (reset),
        .issue_rd   (mem_cs & ~mem_we),
        .issue_port (dbg_gnt ? PORT_DBG : PORT_CPU),
        .mem_rdata  (mem_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural SRAM, reference memory image and a
// scoreboard queue of expected read returns.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic       clk;
    logic       reset;
    logic       cpu_req, cpu_we, dbg_req, dbg_we;
    logic [6:0] cpu_addr, dbg_addr, mem_addr;
    logic [7:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_stall, dbg_rvalid;
    logic [7:0] cpu_rdata, dbg_rdata;
    logic       mem_cs, mem_we;

    typedef struct {
        port_id_t   port;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    sb[$];
    logic [7:0] sram    [128];
    logic [7:0] ref_mem [128];
    logic       preload;
    int         errors = 0;
    int         checks = 0;

    dmem_arbiter #(
        .DATA_WIDTH   (8),
        .D_ADDR_WIDTH (7),
        .MAX_WAIT     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_stall  (dbg_stall),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [6:0] a);
        case (a)
            7'h00: return 8'h11;
            7'h01: return 8'h22;
            7'h02: return 8'h33;
            7'h03: return 8'h44;
            7'h10: return 8'h5A;
            default: return {1'b0, a} ^ 8'h96;
        endcase
    endfunction

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) sram[i] <= init_val(7'(i));
        end else if (mem_cs) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, then move past the rising edge.
    task automatic step(input logic exp_c, input logic exp_d, input string tag);
        rd_exp_t    e;
        logic       ec_rv, ed_rv, ewe;
        logic [7:0] ec_rd, ed_rd, ewd;
        logic [6:0] ea;
        @(negedge clk);
        ec_rv = 1'b0; ed_rv = 1'b0; ec_rd = '0; ed_rd = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == PORT_DBG) begin ed_rv = 1'b1; ed_rd = e.data; end
            else                    begin ec_rv = 1'b1; ec_rd = e.data; end
        end
        check({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(ec_rv));
        check({tag, ".cpu_rdata"},  32'(cpu_rdata),  32'(ec_rd));
        check({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'(ed_rv));
        check({tag, ".dbg_rdata"},  32'(dbg_rdata),  32'(ed_rd));
        check({tag, ".cpu_gnt"},    32'(cpu_gnt),    32'(exp_c));
        check({tag, ".dbg_gnt"},    32'(dbg_gnt),    32'(exp_d));
        check({tag, ".cpu_stall"},  32'(cpu_stall),  32'(cpu_req & ~exp_c));
        check({tag, ".mem_cs"},     32'(mem_cs),     32'(exp_c | exp_d));
        ewe = 1'b0; ea = '0; ewd = '0;
        if (exp_c) begin
            ewe = cpu_we; ea = cpu_addr; ewd = cpu_wdata;
        end else if (exp_d) begin
            ewe = dbg_we; ea = dbg_addr; ewd = dbg_wdata;
        end
        check({tag, ".mem_we"},    32'(mem_we),    32'(ewe));
        check({tag, ".mem_addr"},  32'(mem_addr),  32'(ea));
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(ewd));
        if (exp_c || exp_d) begin
            if (ewe) ref_mem[ea] = ewd;
            else     sb.push_back('{port: (exp_d ? PORT_DBG : PORT_CPU), data: ref_mem[ea]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic starve_run(input int n, input string tag);
        int caddr = 8'h20;
        int daddr = 8'h40;
        logic exp_d;
        for (int i = 0; i < n; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'(caddr); cpu_wdata = '0;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'(daddr); dbg_wdata = '0;
            exp_d = ((i % 5) == 4);
            step(~exp_d, exp_d, $sformatf("%s%0d", tag, i));
            if (exp_d) daddr++;
            else       caddr++;
        end
        idle();
        step(1'b0, 1'b0, {tag, "_drain"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(7'(i));
        reset   = 1'b0;
        preload = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Requests during reset are ignored and all outputs are quiet.
        cpu_req = 1'b1; dbg_req = 1'b1;
        step(1'b0, 1'b0, "rst");
        check("rst.wait_cnt", 32'(dut.wait_cnt), 32'd0);
        idle();
        preload = 1'b0;
        reset   = 1'b1;
        step(1'b0, 1'b0, "idle");

        // CPU-only read of 0x10.
        cpu_req = 1'b1; cpu_addr = 7'h10;
        step(1'b1, 1'b0, "cpu_rd");
        idle();
        step(1'b0, 1'b0, "cpu_rd_ret");

        // Continuous traffic: CPU x4 then one debug slot, twice.
        starve_run(10, "starve");

        // Debug-only write of 0xA5 to 0x7F, then CPU reads it back.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h7F; dbg_wdata = 8'hA5;
        step(1'b0, 1'b1, "dbg_wr");
        idle();
        check("dbg_wr.wait_cnt", 32'(dut.wait_cnt), 32'd0);
        cpu_req = 1'b1; cpu_addr = 7'h7F;
        step(1'b1, 1'b0, "cpu_rd7f");
        idle();
        step(1'b0, 1'b0, "cpu_rd7f_ret");
        check("cpu_rd7f.ref", 32'(ref_mem[7'h7F]), 32'h00A5);

        // Back-to-back CPU reads of 0..3.
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1'b1; cpu_addr = 7'(i);
            step(1'b1, 1'b0, $sformatf("b2b%0d", i));
        end
        idle();
        step(1'b0, 1'b0, "b2b_ret");

        // Reset pulled the cycle after a read grant drops the pending read.
        cpu_req = 1'b1; cpu_addr = 7'h05;
        dbg_req = 1'b1; dbg_addr = 7'h06;
        step(1'b1, 1'b0, "mid_rd");
        reset = 1'b0;
        sb.delete();
        step(1'b0, 1'b0, "mid_rst0");
        step(1'b0, 1'b0, "mid_rst1");
        idle();
        reset = 1'b1;
        step(1'b0, 1'b0, "mid_rel");
        check("mid_rel.wait_cnt", 32'(dut.wait_cnt), 32'd0);

        // Starvation counter restarts cleanly after reset.
        starve_run(5, "post_rst");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the CPU's single-port data SRAM (128 × 8 by default) between the CPU data path and the debug/trace access port. The CPU has fixed priority. A starvation counter guarantees the debug port a slot after a bounded wait. The block sits between the CPU core's load/store unit and the SRAM macro. It issues at most one SRAM access per cycle and routes the 1-cycle-latency read data back to the requester that issued the read.

## Interface
- `DATA_WIDTH`, 8, SRAM word width
- `D_ADDR_WIDTH`, 7, SRAM address width (128 bytes)
- `MAX_WAIT`, 4, maximum consecutive cycles a pending debug request loses to the CPU; legal range ≥ 1

Ports:
- `clk`  in  1  system clock; all logic is rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU access request; `addr`/`we`/`wdata` held stable until granted
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  D_ADDR_WIDTH  CPU address
- `cpu_wdata`  in  DATA_WIDTH  CPU write data
- `cpu_gnt`  out  1  access issued this cycle
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rvalid`  out  1  read data valid
- `cpu_rdata`  out  DATA_WIDTH  read data
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as the CPU set, for the debug port
- `mem_cs`  out  1  SRAM chip select
- `mem_we`  out  1  SRAM write enable
- `mem_addr`  out  D_ADDR_WIDTH  SRAM address
- `mem_wdata`  out  DATA_WIDTH  SRAM write data
- `mem_rdata`  in  DATA_WIDTH  SRAM read data, valid the cycle after a read select

## Operation
Arbitration is combinational and evaluated each cycle.
- `dbg_prio = (wait_cnt == MAX_WAIT)`.
- When `dbg_prio` is 1 and `dbg_req` is 1, grant the debug port. Otherwise, grant the CPU if `cpu_req` is 1. Otherwise, grant the debug port if `dbg_req` is 1.
- At most one grant per cycle.
- `mem_cs` = any grant. `mem_we`, `mem_addr` and `mem_wdata` are muxed from the granted port. They are 0 when there is no grant.

Starvation counter `wait_cnt` (width `$clog2(MAX_WAIT+1)`):
- Increments when `dbg_req & ~dbg_gnt`.
- Clears to 0 on `dbg_gnt`, or when `dbg_req` is 0.
- Saturates at `MAX_WAIT`.

Read-return pipeline:
- Registered `rd_pend` and `rd_owner` capture (grant & ~we) and the granted port.
- Next cycle, the owner's `rvalid` is 1 and its `rdata` = `mem_rdata`.
- The non-owner's `rdata` is 0.
- Writes produce no `rvalid`.

Ordering:
- Accesses complete in grant order.
- A write granted in cycle N is visible to a read granted in cycle N+1 or later, regardless of port.
- No address-conflict logic is needed, because only one access is issued per cycle.

Reset values: `wait_cnt` = 0, `rd_pend` = 0, `rd_owner` = CPU, all `rvalid` = 0, all `rdata` = 0. Grants and mem outputs follow their inputs combinationally, but are forced to 0 while `reset` is low.

## Timing
- Grant latency is 0 cycles: `gnt` is in the same cycle as `req` when the port wins.
- Read data latency is 1 cycle after `gnt`.
- Back-to-back reads from one port give `rvalid` on consecutive cycles.
- Worst-case debug wait under continuous CPU traffic is `MAX_WAIT` cycles; debug is granted on cycle `MAX_WAIT`+1.
- The CPU then loses exactly one cycle (`cpu_stall` = 1) and regains priority next cycle.
- Reset asserted mid-operation: a pending read is dropped, and no `rvalid` follows after reset releases.
- Requesters must re-issue any access that was not granted.
- Requests are sampled only while `reset` is high.

## Structure
- Shared package/header (alongside the `defines.vh` contents) holds:
  - the port-ID constants `PORT_CPU` = 0 and `PORT_DBG` = 1;
  - the default `MAX_WAIT`.
- One natural sub-module, `dmem_rd_return`: the `rd_pend`/`rd_owner` register pair plus the `rdata`/`rvalid` demux.
- Arbitration and the starvation counter stay in the top module.

## Test plan
- CPU-only read, SRAM[0x10] = 0x5A: `cpu_req` with addr 0x10 → `cpu_gnt` the same cycle; next cycle `cpu_rvalid` = 1 and `cpu_rdata` = 0x5A; `dbg_rvalid` = 0.
- Continuous `cpu_req` and `dbg_req` (reads), `MAX_WAIT` = 4 → grants repeat the pattern CPU, CPU, CPU, CPU, DBG; `cpu_stall` is high on every fifth cycle.
- Debug write 0xA5 to 0x7F, then a CPU read of 0x7F the next cycle → `cpu_rdata` = 0xA5 with `cpu_rvalid` one cycle after the CPU grant.
- CPU reads addresses 0–3 back-to-back, holding 0x11, 0x22, 0x33, 0x44 → `cpu_rvalid` high for 4 consecutive cycles with data in order, and `mem_cs` high for 4 cycles.
- Read granted in cycle N, `reset` pulled low in cycle N+1 → `rvalid` and `rdata` are 0 during and after reset; `wait_cnt` = 0 on release.
- Debug-only write with `cpu_req` = 0 → `dbg_gnt` in the same cycle, `mem_we` = 1, and `wait_cnt` stays 0.
